// File: rtl/hv_abist_pkg.sv
// hv_abist_pkg: shared state encoding, ADC codes and channel indices for the HV BIST responder
package hv_abist_pkg;
  localparam int CLK_M = 48;
  typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_FLT, ST_REL, ST_RUN} st_e;
  localparam logic [9:0] ADC_IDLE_CODE    = 10'h000;
  localparam logic [9:0] ADC_BIST_CODE_HI = 10'h200;
  localparam logic [9:0] ADC_BIST_CODE_LO = 10'h1FF;
  localparam logic [9:0] ADC_ERR_CODE     = 10'h3FF;
  localparam logic [9:0] ADC_WIN_LO       = 10'h1F8;
  localparam logic [9:0] ADC_WIN_HI       = 10'h207;
  localparam int CH_OV     = 0;
  localparam int CH_OT     = 1;
  localparam int CH_OPSCOD = 2;
  localparam int CH_OC     = 3;
  localparam int CH_SC     = 4;
  localparam int CH_ADC    = 5;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/hv_abist_rsp_ch.sv
// hv_abist_rsp_ch: one emulated fault flag; arms on request, raises after RSP_DLY_CYC, holds REL_DLY_CYC after drop
module hv_abist_rsp_ch
  import hv_abist_pkg::*;
#(
  parameter int RSP_DLY_CYC = 8,
  parameter int REL_DLY_CYC = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_req,
  input  logic i_mask,
  output logic o_flag,
  output logic o_act_nxt
);
  localparam int CW = $clog2(max2(RSP_DLY_CYC, REL_DLY_CYC) + 1);
  localparam logic [CW-1:0] RSP_M1 = CW'(RSP_DLY_CYC - 1);
  localparam logic [CW-1:0] REL_M1 = CW'(REL_DLY_CYC - 1);
  st_e st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  always_comb begin
    st_nxt  = st;
    cnt_nxt = '0;
    cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    unique case (st)
      ST_IDLE: st_nxt = i_req ? ST_ARM : ST_IDLE;
      ST_ARM: begin
        st_nxt  = !i_req ? ST_IDLE : (cnt == RSP_M1) ? ST_FLT : ST_ARM;
        cnt_nxt = cnt_inc;
      end
      ST_FLT: st_nxt = i_req ? ST_FLT : ST_REL;
      ST_REL: begin
        st_nxt  = (cnt == REL_M1) ? ST_IDLE : ST_REL;
        cnt_nxt = cnt_inc;
      end
      default: st_nxt = ST_IDLE;
    endcase
    if (!i_en) begin
      st_nxt  = ST_IDLE;
      cnt_nxt = '0;
    end
  end
  assign o_act_nxt = st_nxt != ST_IDLE;
  // the mask only gates the flag, so busy still reflects the sequencing
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      st     <= ST_IDLE;
      cnt    <= '0;
      o_flag <= 1'b0;
    end else begin
      st     <= st_nxt;
      cnt    <= cnt_nxt;
      o_flag <= (st_nxt == ST_FLT || st_nxt == ST_REL) && !i_mask;
    end
endmodule

// File: rtl/hv_abist_rsp.sv
// hv_abist_rsp: analog-side responder for HV BIST; five fault flags plus an emulated ADC.
// Define HV_ABIST_RSP_ERR_INJ_EN to add the i_inj_mask error-injection input.
module hv_abist_rsp
  import hv_abist_pkg::*;
#(
  parameter int ADC_DW      = 10,
  parameter int RSP_DLY_CYC = 8,
  parameter int REL_DLY_CYC = 4,
  parameter int ADC_DLY_CYC = 16,
  parameter int ADC_SMP_CYC = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rsp_en,
  input  logic              i_bist_hv_ov,
  input  logic              i_bist_hv_ot,
  input  logic              i_bist_hv_opscod,
  input  logic              i_bist_hv_oc,
  input  logic              i_bist_hv_sc,
  input  logic              i_bist_hv_adc,
`ifdef HV_ABIST_RSP_ERR_INJ_EN
  input  logic [5:0]        i_inj_mask,
`endif
  output logic              o_hv_vcc_ov,
  output logic              o_hv_ot,
  output logic              o_hv_desat_flt,
  output logic              o_hv_oc,
  output logic              o_hv_scp_flt,
  output logic [ADC_DW-1:0] o_hv_adc_data1,
  output logic [ADC_DW-1:0] o_hv_adc_data2,
  output logic              o_rsp_busy
);
  localparam int AW = $clog2(max2(ADC_DLY_CYC, ADC_SMP_CYC) + 1);
  localparam logic [AW-1:0] DLY_M1 = AW'(ADC_DLY_CYC - 1);
  localparam logic [AW-1:0] SMP_M1 = AW'(ADC_SMP_CYC - 1);
  logic [5:0] mask;
`ifdef HV_ABIST_RSP_ERR_INJ_EN
  assign mask = i_inj_mask;
`else
  assign mask = '0;
`endif
  logic [4:0] req, flag, act_nxt;
  assign req = {i_bist_hv_sc, i_bist_hv_oc, i_bist_hv_opscod, i_bist_hv_ot, i_bist_hv_ov};
  for (genvar i = 0; i < 5; i++) begin : g_ch
    hv_abist_rsp_ch #(.RSP_DLY_CYC(RSP_DLY_CYC), .REL_DLY_CYC(REL_DLY_CYC)) u_ch (
      .i_clk(i_clk), .i_rst(i_rst), .i_en(i_rsp_en), .i_req(req[i]), .i_mask(mask[i]),
      .o_flag(flag[i]), .o_act_nxt(act_nxt[i])
    );
  end
  assign o_hv_vcc_ov    = flag[CH_OV];
  assign o_hv_ot        = flag[CH_OT];
  assign o_hv_desat_flt = flag[CH_OPSCOD];
  assign o_hv_oc        = flag[CH_OC];
  assign o_hv_scp_flt   = flag[CH_SC];
  st_e ast, ast_nxt;
  logic [AW-1:0] acnt, acnt_nxt, acnt_inc;
  logic ph, ph_nxt;
  always_comb begin
    ast_nxt  = ast;
    acnt_nxt = '0;
    ph_nxt   = ph;
    acnt_inc = (acnt == '1) ? acnt : acnt + 1'b1;
    unique case (ast)
      ST_IDLE: begin
        ast_nxt = i_bist_hv_adc ? ST_ARM : ST_IDLE;
        ph_nxt  = 1'b0;
      end
      ST_ARM: begin
        ast_nxt  = !i_bist_hv_adc ? ST_IDLE : (acnt == DLY_M1) ? ST_RUN : ST_ARM;
        acnt_nxt = (acnt == DLY_M1) ? '0 : acnt_inc;
      end
      ST_RUN: begin
        ast_nxt  = i_bist_hv_adc ? ST_RUN : ST_IDLE;
        acnt_nxt = (acnt == SMP_M1) ? '0 : acnt_inc;
        ph_nxt   = (acnt == SMP_M1) ? !ph : ph;
      end
      default: ast_nxt = ST_IDLE;
    endcase
    if (!i_rsp_en) begin
      ast_nxt  = ST_IDLE;
      acnt_nxt = '0;
    end
  end
  // data2 carries the opposite phase, so both samples stay in the window
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      ast            <= ST_IDLE;
      acnt           <= '0;
      ph             <= 1'b0;
      o_hv_adc_data1 <= ADC_DW'(ADC_IDLE_CODE);
      o_hv_adc_data2 <= ADC_DW'(ADC_IDLE_CODE);
      o_rsp_busy     <= 1'b0;
    end else begin
      ast            <= ast_nxt;
      acnt           <= acnt_nxt;
      ph             <= ph_nxt;
      o_hv_adc_data1 <= ast_nxt != ST_RUN ? ADC_DW'(ADC_IDLE_CODE) : mask[CH_ADC] ? ADC_DW'(ADC_ERR_CODE) :
                        ph_nxt ? ADC_DW'(ADC_BIST_CODE_LO) : ADC_DW'(ADC_BIST_CODE_HI);
      o_hv_adc_data2 <= ast_nxt != ST_RUN ? ADC_DW'(ADC_IDLE_CODE) : mask[CH_ADC] ? ADC_DW'(ADC_ERR_CODE) :
                        ph_nxt ? ADC_DW'(ADC_BIST_CODE_HI) : ADC_DW'(ADC_BIST_CODE_LO);
      o_rsp_busy     <= |act_nxt || ast_nxt != ST_IDLE;
    end
endmodule

// File: tb/tb_hv_abist_rsp.sv
// tb_hv_abist_rsp: directed vector table, async-reset sequence and randomized run against a timing model
module tb_hv_abist_rsp;
  localparam int RSP = 8;
  localparam int REL = 4;
  localparam int ADLY = 16;
  localparam int SMP = 4;
  localparam logic [9:0] H = 10'h200;
  localparam logic [9:0] L = 10'h1FF;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b1;
  logic [5:0] req = '0;
  logic ov, ot, ops, oc, sc, busy;
  logic [9:0] d1, d2;
  logic [4:0] flg;
  int n_chk = 0;
  int n_fail = 0;
  int age[6];
  int rel[6];
  assign flg = {sc, oc, ops, ot, ov};
  always #5 clk = ~clk;
  hv_abist_rsp dut (
    .i_clk(clk), .i_rst(rst), .i_rsp_en(en),
    .i_bist_hv_ov(req[0]), .i_bist_hv_ot(req[1]), .i_bist_hv_opscod(req[2]),
    .i_bist_hv_oc(req[3]), .i_bist_hv_sc(req[4]), .i_bist_hv_adc(req[5]),
`ifdef HV_ABIST_RSP_ERR_INJ_EN
    .i_inj_mask(6'b0),
`endif
    .o_hv_vcc_ov(ov), .o_hv_ot(ot), .o_hv_desat_flt(ops), .o_hv_oc(oc), .o_hv_scp_flt(sc),
    .o_hv_adc_data1(d1), .o_hv_adc_data2(d2), .o_rsp_busy(busy)
  );
  typedef struct {
    logic [5:0] req;
    logic       en;
    int         n;
    logic [4:0] flg;
    logic [9:0] d1;
    logic [9:0] d2;
    logic       bsy;
  } vec_t;
  vec_t tv[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic chk_all(input string nm, input logic [4:0] ef, input logic [9:0] e1, input logic [9:0] e2, input logic eb);
    chk({nm, "_flags"}, 32'(flg), 32'(ef));
    chk({nm, "_d1"}, 32'(d1), 32'(e1));
    chk({nm, "_d2"}, 32'(d2), 32'(e2));
    chk({nm, "_busy"}, 32'(busy), 32'(eb));
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // timing model: age = samples since a channel armed, rel = release cycles still owed
  task automatic model_step(input logic [5:0] r, input logic e);
    for (int c = 0; c < 6; c++) begin
      if (!e) begin
        age[c] = -1;
        rel[c] = 0;
      end else if (rel[c] > 0) rel[c]--;
      else if (age[c] < 0) age[c] = r[c] ? 0 : -1;
      else if (!r[c]) begin
        if (c < 5 && age[c] >= RSP) rel[c] = REL;
        age[c] = -1;
      end else age[c]++;
    end
  endtask
  task automatic model_chk();
    logic [4:0] ef;
    logic [9:0] e1, e2;
    logic eb;
    ef = '0;
    eb = 1'b0;
    for (int c = 0; c < 5; c++) ef[c] = age[c] >= RSP || rel[c] > 0;
    for (int c = 0; c < 6; c++) eb |= age[c] >= 0 || rel[c] > 0;
    e1 = 10'h000;
    e2 = 10'h000;
    if (age[5] >= ADLY) begin
      e1 = (((age[5] - ADLY) / SMP) % 2 == 0) ? H : L;
      e2 = ~e1;
    end
    chk_all("rand", ef, e1, e2, eb);
  endtask
  initial begin
    tv.push_back('{6'h01, 1, 8,  5'h00, 0, 0, 1});
    tv.push_back('{6'h01, 1, 1,  5'h01, 0, 0, 1});
    tv.push_back('{6'h01, 1, 91, 5'h01, 0, 0, 1});
    tv.push_back('{6'h00, 1, 4,  5'h01, 0, 0, 1});
    tv.push_back('{6'h00, 1, 1,  5'h00, 0, 0, 0});
    tv.push_back('{6'h08, 1, 5,  5'h00, 0, 0, 1});
    tv.push_back('{6'h00, 1, 1,  5'h00, 0, 0, 0});
    tv.push_back('{6'h20, 1, 16, 5'h00, 0, 0, 1});
    tv.push_back('{6'h20, 1, 1,  5'h00, H, L, 1});
    tv.push_back('{6'h20, 1, 3,  5'h00, H, L, 1});
    tv.push_back('{6'h20, 1, 1,  5'h00, L, H, 1});
    tv.push_back('{6'h20, 1, 4,  5'h00, H, L, 1});
    tv.push_back('{6'h20, 1, 39, 5'h00, L, H, 1});
    tv.push_back('{6'h00, 1, 1,  5'h00, 0, 0, 0});
    tv.push_back('{6'h3F, 1, 8,  5'h00, 0, 0, 1});
    tv.push_back('{6'h3F, 1, 1,  5'h1F, 0, 0, 1});
    tv.push_back('{6'h3F, 1, 7,  5'h1F, 0, 0, 1});
    tv.push_back('{6'h3F, 1, 1,  5'h1F, H, L, 1});
    tv.push_back('{6'h00, 1, 1,  5'h1F, 0, 0, 1});
    tv.push_back('{6'h00, 1, 3,  5'h1F, 0, 0, 1});
    tv.push_back('{6'h00, 1, 1,  5'h00, 0, 0, 0});
    tv.push_back('{6'h01, 1, 9,  5'h01, 0, 0, 1});
    tv.push_back('{6'h01, 0, 1,  5'h00, 0, 0, 0});
    tv.push_back('{6'h01, 0, 3,  5'h00, 0, 0, 0});
    tv.push_back('{6'h01, 1, 8,  5'h00, 0, 0, 1});
    tv.push_back('{6'h01, 1, 1,  5'h01, 0, 0, 1});
    tv.push_back('{6'h00, 1, 1,  5'h01, 0, 0, 1});
    tv.push_back('{6'h01, 1, 3,  5'h01, 0, 0, 1});
    tv.push_back('{6'h01, 1, 1,  5'h00, 0, 0, 0});
    tv.push_back('{6'h01, 1, 1,  5'h00, 0, 0, 1});
    tv.push_back('{6'h01, 1, 7,  5'h00, 0, 0, 1});
    tv.push_back('{6'h01, 1, 1,  5'h01, 0, 0, 1});
    tv.push_back('{6'h00, 1, 5,  5'h00, 0, 0, 0});
    tv.push_back('{6'h20, 1, 10, 5'h00, 0, 0, 1});
    tv.push_back('{6'h00, 1, 1,  5'h00, 0, 0, 0});
    tick(2);
    chk_all("reset", 5'h00, 10'h000, 10'h000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #6;
    for (int i = 0; i < tv.size(); i++) begin
      req = tv[i].req;
      en  = tv[i].en;
      tick(tv[i].n);
      chk_all($sformatf("vec%0d", i), tv[i].flg, tv[i].d1, tv[i].d2, tv[i].bsy);
    end
    req = 6'h22;
    tick(20);
    chk_all("ot_flt", 5'h02, H, L, 1'b1);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 5'h00, 10'h000, 10'h000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 6'h02;
    tick(8);
    chk_all("rearm_wait", 5'h00, 10'h000, 10'h000, 1'b1);
    tick(1);
    chk_all("rearm_flag", 5'h02, 10'h000, 10'h000, 1'b1);
    req = 6'h00;
    tick(5);
    chk_all("rearm_idle", 5'h00, 10'h000, 10'h000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      age[c] = -1;
      rel[c] = 0;
    end
    for (int t = 0; t < 3000; t++) begin
      logic [5:0] r;
      logic e;
      for (int c = 0; c < 6; c++)
        if ($urandom_range(c == 5 ? 23 : 11, 0) == 0) req[c] = ~req[c];
      en = $urandom_range(99, 0) != 0;
      r = req;
      e = en;
      tick(1);
      model_step(r, e);
      model_chk();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
